// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
//   Round-robin arbiter that shares one 4:1 single-bit mux among four bit-serial
//   sources. An owner keeps the grant until it drops its request. On release the
//   next pending requester is granted at the same edge, so there is no idle cycle.
//   The releasing owner is searched last.
//
//   Optional feature: define MUX_ARB_TIMEOUT_EN to force a release after MAX_HOLD
//   cycles of ownership, but only while another requester is waiting.
//
// Parameters
//   MAX_HOLD     cycles an owner may hold the grant while others wait (timeout only)
//   CNT_W        hold-counter width; 2**CNT_W must exceed MAX_HOLD
// Ports
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_req        request per source; held high for the whole ownership
//   i_data       source bits, i_data[0]=I0 .. i_data[3]=I3
//   i_out_ready  downstream accepts o_out_data this cycle
//   o_gnt        one-hot grant, registered; 0000 when idle
//   o_sel        mux select, registered; index of the grant bit (retained in idle)
//   o_out_data   i_data[o_sel]
//   o_out_valid  granted and the owner still requests
//   o_xfer       o_out_valid && i_out_ready
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_req,
  input  logic [0:3] i_data,
  input  logic       i_out_ready,
  output logic [3:0] o_gnt,
  output logic [1:0] o_sel,
  output logic       o_out_data,
  output logic       o_out_valid,
  output logic       o_xfer
);

  typedef enum logic {StIdle, StGrant} state_e;

  // Elaboration guard: the hold counter must be able to reach MAX_HOLD-1.
  if ((2 ** CNT_W) <= MAX_HOLD) begin : g_bad_cnt_w
    $error("mux4_rr_arbiter: CNT_W too small for MAX_HOLD");
  end

  state_e     r_state, w_state_d;
  logic [3:0] r_gnt, w_gnt_d;
  logic [1:0] r_sel, w_sel_d;
  logic [1:0] r_ptr, w_ptr_d;
  logic [3:0] w_others;
  logic       w_release;
  logic       w_cnt_clr;

  // First set bit of mask, scanning start, start+1, ... modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] mask, input logic [1:0] start);
    logic [1:0] idx;
    rr_pick = start;
    // Scan backwards so the nearest candidate is the last one written.
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (mask[idx]) rr_pick = idx;
    end
  endfunction

  // Requests other than the current owner's; used for both handoff and timeout.
  assign w_others = i_req & ~r_gnt;

`ifdef MUX_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_hold_cnt, w_hold_cnt_d;
  logic             w_timeout;

  assign w_timeout = (r_hold_cnt == CNT_W'(MAX_HOLD - 1)) && (|w_others);
  assign w_release = !i_req[r_sel] || w_timeout;

  always_comb begin
    w_hold_cnt_d = r_hold_cnt;
    if (w_cnt_clr) begin
      w_hold_cnt_d = '0;
    end else if (r_state == StGrant && r_hold_cnt != '1) begin
      w_hold_cnt_d = r_hold_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold_cnt <= '0;
    end else begin
      r_hold_cnt <= w_hold_cnt_d;
    end
  end
`else
  assign w_release = !i_req[r_sel];
`endif

  always_comb begin
    w_state_d = r_state;
    w_gnt_d   = r_gnt;
    w_sel_d   = r_sel;
    w_ptr_d   = r_ptr;
    w_cnt_clr = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (|i_req) begin
          w_state_d = StGrant;
          w_sel_d   = rr_pick(i_req, r_ptr);
          w_gnt_d   = 4'b0001 << w_sel_d;
          w_cnt_clr = 1'b1;
        end
      end
      StGrant: begin
        if (w_release) begin
          w_ptr_d = r_sel + 2'd1;
          // Owner is excluded from w_others, so it is only re-granted later via
          // IDLE when nobody else is pending.
          if (|w_others) begin
            w_sel_d   = rr_pick(w_others, r_sel + 2'd1);
            w_gnt_d   = 4'b0001 << w_sel_d;
            w_cnt_clr = 1'b1;
          end else begin
            w_state_d = StIdle;
            w_gnt_d   = 4'b0000;
          end
        end
      end
      default: begin
        w_state_d = StIdle;
        w_gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'd0;
      r_ptr   <= 2'd0;
    end else begin
      r_state <= w_state_d;
      r_gnt   <= w_gnt_d;
      r_sel   <= w_sel_d;
      r_ptr   <= w_ptr_d;
    end
  end

  assign o_gnt       = r_gnt;
  assign o_sel       = r_sel;
  assign o_out_data  = i_data[r_sel];
  assign o_out_valid = (r_state == StGrant) && i_req[r_sel];
  assign o_xfer      = o_out_valid && i_out_ready;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

  localparam int MaxHold = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [0:3] data = 4'b0000;
  logic       out_ready = 1'b0;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       out_data, out_valid, xfer;

  int n_total = 0;
  int n_pass  = 0;

  mux4_rr_arbiter #(.MAX_HOLD(MaxHold), .CNT_W(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (req),
    .i_data      (data),
    .i_out_ready (out_ready),
    .o_gnt       (gnt),
    .o_sel       (sel),
    .o_out_data  (out_data),
    .o_out_valid (out_valid),
    .o_xfer      (xfer)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Wait for the next rising edge, then settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 4'b0000;
    data = 4'b0000;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Reference model: owner index (-1 when idle), search pointer, cycles held.
  int m_owner, m_ptr, m_held, m_sel;

  task automatic model_reset();
    m_owner = -1;
    m_ptr = 0;
    m_held = 0;
    m_sel = 0;
  endtask

  task automatic model_step(input logic [3:0] r);
    int nxt;
    bit drop, tmo;
    if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
      end
      if (m_owner >= 0) begin
        m_held = 0;
        m_sel = m_owner;
      end
    end else begin
      drop = !r[m_owner];
      tmo = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
      tmo = (m_held == MaxHold - 1) && ((r & ~(4'b0001 << m_owner)) != 4'b0000);
`endif
      if (drop || tmo) begin
        m_ptr = (m_owner + 1) % 4;
        nxt = -1;
        for (int k = 0; k < 3; k++) begin
          if (nxt < 0 && r[(m_owner + 1 + k) % 4]) nxt = (m_owner + 1 + k) % 4;
        end
        m_owner = nxt;
        m_held = 0;
        if (nxt >= 0) m_sel = nxt;
      end else begin
        m_held++;
      end
    end
  endtask

  typedef struct {
    logic [3:0] req;
    logic [0:3] data;
    logic       rdy;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       odata;
    logic       xfer;
  } vec_t;

  vec_t vec[13];

  initial begin
    logic [3:0] exp_gnt;
    logic       exp_valid;

    vec[0]  = '{4'b1111, 4'b1010, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0};
    vec[1]  = '{4'b1110, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0};
    vec[2]  = '{4'b1101, 4'b1010, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b1};
    vec[3]  = '{4'b1011, 4'b1010, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0};
    vec[4]  = '{4'b0111, 4'b1010, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1};
    vec[5]  = '{4'b1110, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0};
    vec[6]  = '{4'b1000, 4'b1010, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1};
    vec[7]  = '{4'b0000, 4'b1010, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0};
    vec[8]  = '{4'b0100, 4'b0010, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b1};
    vec[9]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0};
    vec[10] = '{4'b0001, 4'b1000, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0};
    vec[11] = '{4'b1111, 4'b1000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1};
    vec[12] = '{4'b0000, 4'b1000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0};

    // Async reset with all requests high, checked before any clock edge.
    #2;
    req = 4'b1111;
    rst_n = 1'b0;
    #1;
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_sel", 32'(sel), 32'h0);
    chk("reset_valid", 32'(out_valid), 32'h0);
    chk("reset_xfer", 32'(xfer), 32'h0);

    // Table: RR rotation, handoff, return to idle, single grant, non-owner noise.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      req = vec[i].req;
      data = vec[i].data;
      out_ready = vec[i].rdy;
      tick();
      chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vec[i].gnt));
      chk($sformatf("vec%0d_sel", i), 32'(sel), 32'(vec[i].sel));
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vec[i].valid));
      chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vec[i].odata));
      chk($sformatf("vec%0d_xfer", i), 32'(xfer), 32'(vec[i].xfer));
    end

    // Timeout: two requesters held high continuously.
    do_reset();
    req = 4'b0011;
    for (int i = 1; i <= 12; i++) begin
      tick();
`ifdef MUX_ARB_TIMEOUT_EN
      exp_gnt = (i <= MaxHold) ? 4'b0001 : 4'b0010;
`else
      exp_gnt = 4'b0001;
`endif
      chk($sformatf("hold_cyc%0d", i), 32'(gnt), 32'(exp_gnt));
    end

    // Reset pulsed mid-grant drops the grant at once; then grant from ptr=0.
    do_reset();
    req = 4'b1000;
    tick();
    chk("pre_rst_gnt", 32'(gnt), 32'h8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("post_rst_gnt", 32'(gnt), 32'h8);
    chk("post_rst_sel", 32'(sel), 32'h3);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) < 3) req = 4'($urandom_range(0, 15));
      data = 4'($urandom_range(0, 15));
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      model_step(req);
      #1;
      exp_gnt = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
      exp_valid = (m_owner >= 0) && req[m_owner];
      chk("rnd_gnt", 32'(gnt), 32'(exp_gnt));
      chk("rnd_sel", 32'(sel), 32'(m_sel));
      chk("rnd_valid", 32'(out_valid), 32'(exp_valid));
      chk("rnd_data", 32'(out_data), (32'(data) >> (3 - m_sel)) & 32'h1);
      chk("rnd_xfer", 32'(xfer), 32'(exp_valid && out_ready));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
